mapper_ram_bridge: RTL and testbench

- Sits directly downstream of the cartridge mapper.
- Consumes the mapper's translated RAM address, chip select and read/not-write, together with the CPU bus strobe and write data.
- Converts each selected access into a single-outstanding request/acknowledge transaction to the shared RAM controller, holds the CPU in wait until it completes, and returns read data.
- One bridge instance per mapper instance; the arbiter lives further downstream.

---
 rtl/mapper_ram_bridge.sv | 130 +++++++++++++
 tb/tb_mapper_ram_bridge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mapper_ram_bridge.sv
// rtl/mapper_ram_bridge.sv - mapper RAM access to single-outstanding req/ack bridge
// Optional single-entry read cache: define MAPPER_RAM_BRIDGE_READ_CACHE_EN.
module mapper_ram_bridge #(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_wr,
  input  logic [7:0]        i_cpu_wdata,
  input  logic [ADDR_W-1:0] i_map_addr,
  input  logic              i_map_ram_cs,
  input  logic              i_map_rnw,
  output logic              o_cpu_wait,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_rdata_valid,
  output logic              o_ram_req,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_din,
  input  logic              i_ram_ack,
  input  logic [7:0]        i_ram_dout,
  output logic              o_timeout_err,
  output logic              o_overrun_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK} state_t;

  // Abort fires on the WAIT_ACK cycle whose increment would make the count reach TIMEOUT.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        w_hit;
  logic        w_accept;

`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
  logic              r_cache_valid;
  logic [ADDR_W-1:0] r_cache_tag;
  logic [7:0]        r_cache_data;
  logic              w_tag_match;

  assign w_tag_match = r_cache_valid && (r_cache_tag == i_map_addr);
  assign w_hit       = w_tag_match && i_map_rnw;
`else
  logic w_unused_wr;

  assign w_unused_wr = i_cpu_wr;
  assign w_hit       = 1'b0;
`endif

  assign w_accept   = i_cpu_req && i_map_ram_cs && !w_hit;
  assign o_cpu_wait = (r_state != S_IDLE) || w_accept;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state           <= S_IDLE;
      r_cnt             <= 8'd0;
      o_ram_req         <= 1'b0;
      o_ram_we          <= 1'b0;
      o_ram_addr        <= '1;
      o_ram_din         <= 8'd0;
      o_cpu_rdata       <= 8'hFF;
      o_cpu_rdata_valid <= 1'b0;
      o_timeout_err     <= 1'b0;
      o_overrun_err     <= 1'b0;
`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
      r_cache_valid     <= 1'b0;
      r_cache_tag       <= '0;
      r_cache_data      <= 8'd0;
`endif
    end else begin
      o_ram_req         <= 1'b0;
      o_cpu_rdata_valid <= 1'b0;
      if ((r_state != S_IDLE) && i_cpu_req) begin
        o_overrun_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            o_ram_addr <= i_map_addr;
            o_ram_din  <= i_cpu_wdata;
            o_ram_we   <= ~i_map_rnw;
            o_ram_req  <= 1'b1;
            r_state    <= S_ISSUE;
          end
`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
          if (i_cpu_req && i_map_ram_cs && w_hit) begin
            o_cpu_rdata       <= r_cache_data;
            o_cpu_rdata_valid <= 1'b1;
          end
          if (w_accept && !i_map_rnw && i_cpu_wr && w_tag_match) begin
            r_cache_data <= i_cpu_wdata;
          end
`endif
        end
        S_ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_ram_ack) begin
            if (!o_ram_we) begin
              o_cpu_rdata       <= i_ram_dout;
              o_cpu_rdata_valid <= 1'b1;
`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
              r_cache_valid     <= 1'b1;
              r_cache_tag       <= o_ram_addr;
              r_cache_data      <= i_ram_dout;
`endif
            end
            r_state <= S_IDLE;
          end else if (r_cnt == LP_CNT_LAST) begin
            if (!o_ram_we) begin
              o_cpu_rdata       <= 8'hFF;
              o_cpu_rdata_valid <= 1'b1;
            end
            o_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_ram_bridge.sv
// tb/tb_mapper_ram_bridge.sv - randomized self-checking bench for mapper_ram_bridge
// Cache scenarios run when MAPPER_RAM_BRIDGE_READ_CACHE_EN is defined.
module tb_mapper_ram_bridge;
  localparam int AW = 27;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          i_reset_n, i_cpu_req, i_cpu_wr, i_map_ram_cs, i_map_rnw, i_ram_ack;
  logic [7:0]    i_cpu_wdata, i_ram_dout;
  logic [AW-1:0] i_map_addr;
  logic          o_cpu_wait, o_cpu_rdata_valid, o_ram_req, o_ram_we;
  logic          o_timeout_err, o_overrun_err;
  logic [7:0]    o_cpu_rdata, o_ram_din;
  logic [AW-1:0] o_ram_addr;

  always #5 clk = ~clk;

  mapper_ram_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_cpu_req(i_cpu_req), .i_cpu_wr(i_cpu_wr),
    .i_cpu_wdata(i_cpu_wdata), .i_map_addr(i_map_addr), .i_map_ram_cs(i_map_ram_cs),
    .i_map_rnw(i_map_rnw), .o_cpu_wait(o_cpu_wait), .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_rdata_valid(o_cpu_rdata_valid), .o_ram_req(o_ram_req), .o_ram_addr(o_ram_addr),
    .o_ram_we(o_ram_we), .o_ram_din(o_ram_din), .i_ram_ack(i_ram_ack), .i_ram_dout(i_ram_dout),
    .o_timeout_err(o_timeout_err), .o_overrun_err(o_overrun_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the CPU and RAM controller should observe.
  logic [7:0]    m_rdata, m_din, m_cdata;
  logic          m_terr, m_oerr, m_we, m_cv;
  logic [AW-1:0] m_addr, m_ctag;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = 8'hFF; m_din = 8'h00; m_we = 1'b0; m_addr = '1;
    m_terr = 1'b0; m_oerr = 1'b0; m_cv = 1'b0; m_ctag = '0; m_cdata = 8'h00;
  endtask

  task automatic idle_inputs();
    i_cpu_req = 1'b0; i_cpu_wr = 1'b0; i_cpu_wdata = 8'h00; i_map_addr = '1;
    i_map_ram_cs = 1'b0; i_map_rnw = 1'b1; i_ram_ack = 1'b0; i_ram_dout = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    model_reset();
  endtask

  // One CPU access; ack arrives dly cycles after the ram_req cycle (dly > TO means too late).
  task automatic do_access(input logic cs, input logic rnw, input logic [AW-1:0] addr,
                           input logic [7:0] wd, input int dly, input logic [7:0] dout,
                           input bit poke);
    int waits = 0, reqs = 0, vld = 0, since = -1, exp_wait;
    logic [7:0]    vdata = 8'h00, exp_v, sdin = 8'h00;
    logic [AW-1:0] saddr = '0;
    logic          swe = 1'b0;
    bit            hit = 0, go, tmo;
`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
    hit = cs && rnw && m_cv && (m_ctag == addr);
`endif
    go  = cs && !hit;
    tmo = go && (dly > TO);

    @(posedge clk); #1;
    i_cpu_req = 1'b1; i_map_ram_cs = cs; i_map_rnw = rnw; i_cpu_wr = !rnw;
    i_map_addr = cs ? addr : '1; i_cpu_wdata = wd;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (o_cpu_wait) waits++;
      if (o_cpu_rdata_valid) begin vld++; vdata = o_cpu_rdata; end
      if (o_ram_req) begin
        reqs++; since = 0; saddr = o_ram_addr; swe = o_ram_we; sdin = o_ram_din;
      end
      i_ram_ack  = (since == dly);
      i_ram_dout = (since == dly) ? dout : 8'($urandom);
      if (poke && since == 1) begin
        i_cpu_req = 1'b1; i_map_ram_cs = 1'b1; i_map_addr = AW'($urandom);
      end
      @(posedge clk); #1;
      i_cpu_req = 1'b0; i_ram_ack = 1'b0; i_map_ram_cs = 1'b0; i_map_addr = '1;
      if (since >= 0) since++;
    end

    exp_wait = go ? (2 + (tmo ? TO : dly)) : 0;
    exp_v    = hit ? m_cdata : (tmo ? 8'hFF : dout);
    if (cs && rnw) m_rdata = exp_v;
    if (go) begin m_addr = addr; m_we = !rnw; m_din = wd; end
    if (tmo) m_terr = 1'b1;
    if (go && poke) m_oerr = 1'b1;
`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
    if (cs && !rnw && m_cv && m_ctag == addr) m_cdata = wd;
    if (go && rnw && !tmo) begin m_cv = 1'b1; m_ctag = addr; m_cdata = dout; end
`endif

    check_eq("ram_req_count", reqs, go ? 1 : 0);
    check_eq("wait_cycles", waits, exp_wait);
    check_eq("rdata_valid_count", vld, (cs && rnw) ? 1 : 0);
    if (cs && rnw) check_eq("rdata_pulse_value", vdata, exp_v);
    if (go) begin
      check_eq("req_addr", saddr, addr);
      check_eq("req_we", swe, !rnw);
      check_eq("req_din", sdin, wd);
    end
    check_eq("cpu_rdata", o_cpu_rdata, m_rdata);
    check_eq("ram_addr_hold", o_ram_addr, m_addr);
    check_eq("ram_we_hold", o_ram_we, m_we);
    check_eq("ram_din_hold", o_ram_din, m_din);
    check_eq("timeout_err", o_timeout_err, m_terr);
    check_eq("overrun_err", o_overrun_err, m_oerr);
  endtask

  logic [AW-1:0] pool [4];

  initial begin
    i_reset_n = 1'b0;
    idle_inputs();
    model_reset();
    do_reset();
    @(negedge clk);
    check_eq("rst_wait", o_cpu_wait, 1'b0);
    check_eq("rst_ram_req", o_ram_req, 1'b0);
    check_eq("rst_ram_addr", o_ram_addr, {AW{1'b1}});
    check_eq("rst_ram_we", o_ram_we, 1'b0);
    check_eq("rst_ram_din", o_ram_din, 8'h00);
    check_eq("rst_rdata", o_cpu_rdata, 8'hFF);
    check_eq("rst_rdata_valid", o_cpu_rdata_valid, 1'b0);
    check_eq("rst_terr", o_timeout_err, 1'b0);
    check_eq("rst_oerr", o_overrun_err, 1'b0);

    do_access(1, 1, 27'h0012345, 8'h00, 2, 8'hA5, 0);
    do_access(1, 0, 27'h0100000, 8'h3C, 3, 8'h00, 0);
    do_access(1, 1, 27'h0000777, 8'h00, 1, 8'h5E, 0);
    do_access(1, 1, 27'h0000778, 8'h00, TO, 8'hC3, 0);
    do_access(0, 1, '1, 8'h00, 2, 8'h00, 0);
    do_access(1, 1, 27'h0000779, 8'h00, TO + 1, 8'h99, 0);
    do_access(1, 0, 27'h0000100, 8'h42, 4, 8'h00, 1);
    do_access(1, 1, 27'h0000200, 8'h00, 2, 8'h81, 0);

    // Reset mid-transaction, then a late ack that must be ignored.
    @(posedge clk); #1;
    i_cpu_req = 1'b1; i_map_ram_cs = 1'b1; i_map_rnw = 1'b1; i_map_addr = 27'h0000055;
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_reset_n = 1'b0;
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    model_reset();
    i_ram_ack = 1'b1; i_ram_dout = 8'h5A;
    @(negedge clk);
    check_eq("midrst_wait", o_cpu_wait, 1'b0);
    check_eq("midrst_ram_req", o_ram_req, 1'b0);
    check_eq("midrst_ram_addr", o_ram_addr, {AW{1'b1}});
    @(posedge clk); #1;
    i_ram_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_valid", o_cpu_rdata_valid, 1'b0);
    check_eq("late_ack_rdata", o_cpu_rdata, 8'hFF);
    check_eq("late_ack_wait", o_cpu_wait, 1'b0);
    check_eq("late_ack_terr", o_timeout_err, 1'b0);

`ifdef MAPPER_RAM_BRIDGE_READ_CACHE_EN
    do_access(1, 1, 27'h0000010, 8'h00, 2, 8'h77, 0);
    do_access(1, 1, 27'h0000010, 8'h00, 2, 8'h00, 0);
    do_access(1, 0, 27'h0000010, 8'h11, 2, 8'h00, 0);
    do_access(1, 1, 27'h0000010, 8'h00, 2, 8'h00, 0);
    do_access(1, 1, 27'h0000020, 8'h00, TO + 2, 8'h33, 0);
    do_access(1, 1, 27'h0000010, 8'h00, 2, 8'h00, 0);
`endif

    pool[0] = 27'h0000010; pool[1] = 27'h0012345; pool[2] = 27'h7FFFFFE; pool[3] = 27'h0000000;
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 2) == 0) ? AW'($urandom) : pool[$urandom_range(0, 3)];
      if (n == 30) do_reset();
      do_access($urandom_range(0, 3) != 0, 1'($urandom), a, 8'($urandom),
                $urandom_range(1, 11), 8'($urandom), $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
